stream_scheduler: RTL and testbench

Weighted round-robin scheduler that decides which of the four transport-stream sources owns the next output slot of the source switch. It watches per-source "full packet ready" flags and issues a one-hot grant that the switch holds for exactly one packet slot (header plus 188-byte packet). The switch's end-of-slot strobe releases the grant. Per-source enable mask and weights are written over the existing SPI register bus, and a watchdog recovers the scheduler if a slot never completes.

---
 rtl/stream_scheduler_pkg.sv | 9 +
 rtl/rr_pick.sv | 14 +
 rtl/stream_scheduler.sv | 84 ++++++++
 tb/tb_stream_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/stream_scheduler_pkg.sv
// stream_scheduler_pkg: register addresses and helpers shared by the stream scheduler
package stream_scheduler_pkg;
  localparam logic [7:0] ADDR_SCHED_EN      = 8'h20;
  localparam logic [7:0] ADDR_SCHED_W_FIRST = 8'h21;
  localparam logic [7:0] ADDR_SCHED_W_LAST  = 8'h24;
  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority picker, first set bit of cand searching upward from start
module rr_pick (
  input  logic [3:0] cand,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);
  always_comb begin
    idx = start;
    for (int i = 3; i >= 0; i--)
      if (cand[start + 2'(i)]) idx = start + 2'(i);
  end
  assign found = |cand;
endmodule

// File: rtl/stream_scheduler.sv
// stream_scheduler: weighted round-robin slot scheduler with SPI-written mask/weights and watchdog
module stream_scheduler
  import stream_scheduler_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int W_BITS  = 4,
  parameter int TIMEOUT = 400
) (
  input  logic             SYS_CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] REQ,
  input  logic             SLOT_DONE,
  input  logic [7:0]       SPI_ADDRESS,
  input  logic [7:0]       SPI_DATA,
  input  logic             RISING_SS,
  output logic [N_SRC-1:0] GRANT,
  output logic             GRANT_VALID,
  output logic [1:0]       GRANT_ID,
  output logic             TIMEOUT_ERR
);
  localparam int WD_BITS = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [N_SRC-1:0] en, cand;
  logic [W_BITS-1:0] w [N_SRC];
  logic [W_BITS-1:0] credit, credit_nx;
  logic [1:0] ptr, ptr_nx, gid, idx;
  logic [WD_BITS-1:0] wd;
  logic [7:0] woff;
  logic found, grant_now, timeout_now, wr_en, wr_w, unused_bits;
  assign cand  = REQ & en;
  assign wr_en = RISING_SS && SPI_ADDRESS == ADDR_SCHED_EN;
  assign wr_w  = RISING_SS && SPI_ADDRESS >= ADDR_SCHED_W_FIRST && SPI_ADDRESS <= ADDR_SCHED_W_LAST;
  assign woff  = SPI_ADDRESS - ADDR_SCHED_W_FIRST;
  assign unused_bits = ^woff[7:2];
  rr_pick u_pick (.cand(cand), .start(ptr + 2'd1), .found(found), .idx(idx));
  always_ff @(posedge SYS_CLK)
    state <= RST ? IDLE : state_nx;
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    credit_nx   = credit;
    grant_now   = 1'b0;
    timeout_now = 1'b0;
    if (state == IDLE && found) begin
      grant_now = 1'b1;
      state_nx  = BUSY;
      if (cand[ptr] && credit != '0) credit_nx = credit - W_BITS'(1);
      else begin
        ptr_nx    = idx;
        credit_nx = w[idx] - W_BITS'(1);
      end
    end else if (state == BUSY && (SLOT_DONE || wd == WD_BITS'(TIMEOUT - 1))) begin
      state_nx    = IDLE;
      timeout_now = !SLOT_DONE;
    end
  end
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      en          <= '1;
      for (int i = 0; i < N_SRC; i++) w[i] <= W_BITS'(1);
      ptr         <= 2'd3;
      credit      <= '0;
      wd          <= '0;
      gid         <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      ptr         <= ptr_nx;
      credit      <= credit_nx;
      wd          <= state == BUSY ? wd + 1'b1 : '0;
      TIMEOUT_ERR <= timeout_now | (TIMEOUT_ERR & ~(wr_en & SPI_DATA[7]));
      if (grant_now) gid <= ptr_nx;
      if (wr_en) begin
        en <= SPI_DATA[N_SRC-1:0];
        // masking the live source mid-slot forfeits its remaining credit
        if (state == BUSY && !SPI_DATA[gid]) credit <= '0;
      end
      if (wr_w) w[woff[1:0]] <= SPI_DATA[W_BITS-1:0] == '0 ? W_BITS'(1) : SPI_DATA[W_BITS-1:0];
    end
  end
  assign GRANT_VALID = state == BUSY;
  assign GRANT       = GRANT_VALID ? onehot(gid) : '0;
  assign GRANT_ID    = GRANT_VALID ? gid : 2'd0;
endmodule

// File: tb/tb_stream_scheduler.sv
// tb_stream_scheduler: directed stimulus with a grant scoreboard checked by a separate monitor
module tb_stream_scheduler;
  import stream_scheduler_pkg::*;
  localparam int TIMEOUT = 400;
  logic SYS_CLK = 0, RST = 1, SLOT_DONE = 0, RISING_SS = 0;
  logic [3:0] REQ = 0, GRANT;
  logic [7:0] SPI_ADDRESS = 0, SPI_DATA = 0;
  logic GRANT_VALID, TIMEOUT_ERR;
  logic [1:0] GRANT_ID;
  int n_chk = 0, n_fail = 0;
  int q[$];
  logic prev_v = 0;
  int seq2[13] = '{3, 0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3};
  int seq5[5]  = '{0, 0, 2, 0, 2};

  stream_scheduler #(.N_SRC(4), .W_BITS(4), .TIMEOUT(TIMEOUT)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .REQ(REQ), .SLOT_DONE(SLOT_DONE),
    .SPI_ADDRESS(SPI_ADDRESS), .SPI_DATA(SPI_DATA), .RISING_SS(RISING_SS),
    .GRANT(GRANT), .GRANT_VALID(GRANT_VALID), .GRANT_ID(GRANT_ID), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge SYS_CLK) begin
    int e;
    if (GRANT_VALID && !prev_v) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_grant: GRANT=%b expected no grant", GRANT);
      end else begin
        e = q.pop_front();
        check("grant_onehot", int'(GRANT), 1 << e);
        check("grant_id", int'(GRANT_ID), e);
      end
    end
    prev_v = GRANT_VALID;
  end

  task automatic expect_grant(input int id);
    q.push_back(id);
  endtask

  task automatic tick();
    @(posedge SYS_CLK) #1;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20 && !GRANT_VALID; i++) tick();
    check("grant_wait", int'(GRANT_VALID), 1);
  endtask

  task automatic slot_done(input logic [3:0] nreq);
    wait_grant();
    SLOT_DONE = 1;
    REQ = nreq;
    tick();
    SLOT_DONE = 0;
    check("release", int'(GRANT_VALID), 0);
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    SPI_ADDRESS = a;
    SPI_DATA = d;
    RISING_SS = 1;
    tick();
    RISING_SS = 0;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("rst_grant", int'(GRANT), 0);
    check("rst_valid", int'(GRANT_VALID), 0);
    check("rst_id", int'(GRANT_ID), 0);
    check("rst_err", int'(TIMEOUT_ERR), 0);
    RST = 0;
    tick();
    // default weights alternate between sources 0 and 2
    expect_grant(0);
    REQ = 4'b0101;
    tick();
    check("latency", int'(GRANT_VALID), 1);
    slot_done(4'b0101);
    expect_grant(2);
    slot_done(4'b0101);
    expect_grant(0);
    slot_done(4'b0101);
    expect_grant(2);
    slot_done(4'b0000);
    // weight 3 on source 0 with everyone ready
    spi_write(ADDR_SCHED_W_FIRST, 8'h03);
    for (int k = 0; k < 13; k++) begin
      expect_grant(seq2[k]);
      if (k == 0) REQ = 4'hF;
      slot_done(k == 12 ? 4'h0 : 4'hF);
    end
    // mask everything mid-slot
    expect_grant(0);
    REQ = 4'hF;
    wait_grant();
    spi_write(ADDR_SCHED_EN, 8'h00);
    for (int k = 0; k < 3; k++) begin
      check("held_after_mask", int'(GRANT_VALID), 1);
      tick();
    end
    slot_done(4'hF);
    for (int k = 0; k < 5; k++) begin
      check("masked_no_grant", int'(GRANT_VALID), 0);
      tick();
    end
    expect_grant(1);
    spi_write(ADDR_SCHED_EN, 8'h0F);
    slot_done(4'h0);
    // watchdog forced release
    expect_grant(2);
    REQ = 4'b0100;
    wait_grant();
    REQ = 0;
    n = 0;
    while (GRANT_VALID && n < 1000) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_err_set", int'(TIMEOUT_ERR), 1);
    spi_write(ADDR_SCHED_EN, 8'h8F);
    check("timeout_err_clr", int'(TIMEOUT_ERR), 0);
    // SLOT_DONE coinciding with the watchdog limit is a normal completion
    expect_grant(0);
    REQ = 4'b0001;
    wait_grant();
    REQ = 0;
    repeat (TIMEOUT - 1) tick();
    check("held_before_limit", int'(GRANT_VALID), 1);
    SLOT_DONE = 1;
    tick();
    SLOT_DONE = 0;
    check("coincide_release", int'(GRANT_VALID), 0);
    check("coincide_no_err", int'(TIMEOUT_ERR), 0);
    // zero weight stored as one; weight change waits for reload
    spi_write(ADDR_SCHED_W_FIRST + 8'd2, 8'h00);
    spi_write(ADDR_SCHED_W_FIRST, 8'h01);
    for (int k = 0; k < 5; k++) begin
      expect_grant(seq5[k]);
      if (k == 0) REQ = 4'b0101;
      slot_done(k == 4 ? 4'h0 : 4'b0101);
    end
    // reset mid-slot
    expect_grant(3);
    REQ = 4'hF;
    wait_grant();
    expect_grant(0);
    RST = 1;
    tick();
    check("midrst_grant", int'(GRANT), 0);
    check("midrst_valid", int'(GRANT_VALID), 0);
    check("midrst_id", int'(GRANT_ID), 0);
    RST = 0;
    slot_done(4'h0);
    // SLOT_DONE while idle does nothing
    SLOT_DONE = 1;
    tick();
    SLOT_DONE = 0;
    for (int k = 0; k < 3; k++) begin
      check("idle_done_no_grant", int'(GRANT_VALID), 0);
      tick();
    end
    expect_grant(1);
    REQ = 4'b0010;
    slot_done(4'h0);
    repeat (3) tick();
    check("scoreboard_empty", q.size(), 0);
    check("final_err", int'(TIMEOUT_ERR), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
